// File: rtl/bcd_pkg.sv
// Shared BCD digit types and single-digit arithmetic helpers for the decimal
// adder pipeline.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_NINE = 4'd9;

  // Returns {carry, digit}; any raw sum above 9 takes the +6 decimal correction.
  function automatic logic [4:0] bcd_digit_add(input bcd_digit_t a,
                                               input bcd_digit_t b,
                                               input logic       cin);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    if (s > 5'd9) return {1'b1, s[3:0] + 4'd6};
    else          return {1'b0, s[3:0]};
  endfunction

  function automatic bcd_digit_t bcd_nines(input bcd_digit_t d);
    return BCD_NINE - d;
  endfunction

endpackage

// File: rtl/bcd_digit_stage.sv
// One registered decimal digit slice: resolves a single digit and hands its
// carry, op type and valid bit to the next slice.
module bcd_digit_stage
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       adv,
  input  logic       valid_in,
  input  logic       sub_in,
  input  logic       carry_in,
  input  bcd_digit_t a_digit,
  input  bcd_digit_t b_digit,
  output logic       valid_q,
  output logic       sub_q,
  output logic       carry_q,
  output bcd_digit_t digit_q
);

  bcd_digit_t b_eff;
  logic [4:0] digit_res;

  // Subtraction is nines-complement of B plus an inverted borrow-in at digit 0.
  assign b_eff     = sub_in ? bcd_nines(b_digit) : b_digit;
  assign digit_res = bcd_digit_add(a_digit, b_eff, carry_in);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      digit_q <= '0;
    end else if (adv) begin
      valid_q <= valid_in;
      sub_q   <= sub_in;
      carry_q <= digit_res[4];
      digit_q <= digit_res[3:0];
    end
  end

endmodule

// File: rtl/bcd_adder_pipe.sv
// Fully pipelined multi-digit BCD adder/subtractor, one digit per stage.
// Optional BCD_ADDER_CHECK_EN adds out_invalid flagging non-BCD operand digits.
module bcd_adder_pipe
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] in_a,
  input  logic [4*DIGITS-1:0] in_b,
  input  logic                in_sub,
  input  logic                in_cin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] out_sum,
  output logic                out_carry
`ifdef BCD_ADDER_CHECK_EN
  ,
  output logic                out_invalid
`endif
);

  localparam int W = 4 * DIGITS;

  logic adv;

  // Single global stall keeps every stage in lockstep; bubbles move like data.
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

`ifdef BCD_ADDER_CHECK_EN
  logic in_bad;

  always_comb begin
    in_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (in_a[4*i +: 4] > BCD_NINE || in_b[4*i +: 4] > BCD_NINE) in_bad = 1'b1;
    end
  end
`endif

  genvar k;
  for (k = 0; k < DIGITS; k++) begin : g_stage
    // Operands shrink by one digit per stage; results grow by one digit.
    localparam int RW = W - 4*k;

    logic [RW-1:0]    a_cur;
    logic [RW-1:0]    b_cur;
    logic             v_cur;
    logic             s_cur;
    logic             c_cur;
    logic             valid_q;
    logic             sub_q;
    logic             carry_q;
    bcd_digit_t       digit_q;
    logic [4*k+3:0]   res_full;

    if (k == 0) begin : g_head
      assign a_cur    = in_a;
      assign b_cur    = in_b;
      assign v_cur    = in_valid;
      assign s_cur    = in_sub;
      assign c_cur    = in_sub ? ~in_cin : in_cin;
      assign res_full = digit_q;
    end else begin : g_body
      logic [4*k-1:0] res_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  res_q <= '0;
        else if (adv)  res_q <= g_stage[k-1].res_full;
      end

      assign a_cur    = g_stage[k-1].g_skew.a_q;
      assign b_cur    = g_stage[k-1].g_skew.b_q;
      assign v_cur    = g_stage[k-1].valid_q;
      assign s_cur    = g_stage[k-1].sub_q;
      assign c_cur    = g_stage[k-1].carry_q;
      assign res_full = {digit_q, res_q};
    end

    if (k < DIGITS - 1) begin : g_skew
      logic [RW-5:0] a_q;
      logic [RW-5:0] b_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_cur[RW-1:4];
          b_q <= b_cur[RW-1:4];
        end
      end
    end

    bcd_digit_stage u_digit (
      .clk      (clk),
      .reset_n  (reset_n),
      .adv      (adv),
      .valid_in (v_cur),
      .sub_in   (s_cur),
      .carry_in (c_cur),
      .a_digit  (a_cur[3:0]),
      .b_digit  (b_cur[3:0]),
      .valid_q  (valid_q),
      .sub_q    (sub_q),
      .carry_q  (carry_q),
      .digit_q  (digit_q)
    );

`ifdef BCD_ADDER_CHECK_EN
    logic inv_in;
    logic inv_q;

    if (k == 0) begin : g_inv_head
      assign inv_in = in_bad;
    end else begin : g_inv_body
      assign inv_in = g_stage[k-1].inv_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  inv_q <= 1'b0;
      else if (adv)  inv_q <= inv_in;
    end
`endif
  end

  assign out_valid = g_stage[DIGITS-1].valid_q;
  assign out_sum   = g_stage[DIGITS-1].res_full;
  // Borrow is the inverse of the decimal carry out of the complemented add.
  assign out_carry = g_stage[DIGITS-1].sub_q ? ~g_stage[DIGITS-1].carry_q
                                             :  g_stage[DIGITS-1].carry_q;

`ifdef BCD_ADDER_CHECK_EN
  assign out_invalid = g_stage[DIGITS-1].inv_q;
`endif

endmodule
